// File: rtl/booth_bist_ctrl.sv
// booth_bist_ctrl: BIST sequencer that sweeps all operand pairs through a signed multiplier, checks and signs the products
module booth_bist_ctrl #(
    parameter int WIDTH = 4,
    parameter int TIMEOUT = 16,
    parameter logic [2*WIDTH-1:0] MISR_TAPS = 8'hB8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bist_en,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_start,
    input  logic               mul_busy,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [7:0]         err_count,
    output logic [2*WIDTH-1:0] signature
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CHECK, FINISH} state_t;

    state_t state, state_d;
    logic [PW-1:0] vec, vec_d, sig_d, expected;
    logic signed [PW-1:0] sa, sb;
    logic [7:0] tcnt, tcnt_d, err_d;
    logic to_d, done_d, pass_d, tcnt_last;

    assign mul_a = vec[PW-1:WIDTH];
    assign mul_b = vec[WIDTH-1:0];
    assign sa = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
    assign sb = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
    assign expected = sa * sb;
    assign tcnt_last = tcnt == 8'(TIMEOUT - 1);

    // next-state, vector sequencing, timeout, error counting and MISR update
    always_comb begin
        state_d = state;
        vec_d   = vec;
        tcnt_d  = tcnt;
        err_d   = err_count;
        sig_d   = signature;
        to_d    = timeout;
        if (!bist_en) state_d = IDLE;
        else case (state)
            IDLE: begin
                vec_d   = '0;
                err_d   = '0;
                sig_d   = '0;
                to_d    = 1'b0;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                tcnt_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tcnt_d = tcnt + 8'd1;
                if (mul_busy) state_d = WAIT_DONE;
                else if (tcnt_last) begin
                    to_d    = 1'b1;
                    state_d = FINISH;
                end
            end
            WAIT_DONE: begin
                tcnt_d = tcnt + 8'd1;
                if (!mul_busy) state_d = CHECK;
                else if (tcnt_last) begin
                    to_d    = 1'b1;
                    state_d = FINISH;
                end
            end
            CHECK: begin
                err_d   = (mul_product != expected && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
                sig_d   = {signature[PW-2:0], ^(signature & MISR_TAPS)} ^ mul_product;
                vec_d   = &vec ? vec : vec + PW'(1);
                state_d = &vec ? FINISH : LAUNCH;
            end
            default: ;
        endcase
        done_d = state_d == FINISH;
        pass_d = done_d && err_d == 8'd0 && !to_d;
    end

    // state and result registers; start pulse is registered off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            tcnt      <= '0;
            err_count <= '0;
            signature <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            state     <= state_d;
            vec       <= vec_d;
            tcnt      <= tcnt_d;
            err_count <= err_d;
            signature <= sig_d;
            timeout   <= to_d;
            done      <= done_d;
            pass      <= pass_d;
            mul_start <= state_d == LAUNCH;
        end
    end
endmodule

// File: tb/tb_booth_bist_ctrl.sv
// tb_booth_bist_ctrl: directed bench with a behavioural multiplier and MISR model
module tb_booth_bist_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bist_en = 1'b0;
    logic [3:0] mul_a, mul_b;
    logic       mul_start, mul_busy, done, pass, timeout;
    logic [7:0] mul_product, err_count, signature;

    booth_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bist_en(bist_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_busy(mul_busy), .mul_product(mul_product),
        .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .signature(signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        logic [7:0] exp_err;
        logic       exp_pass;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int s0;
    int cnt;
    logic       busy_q;
    logic [7:0] prod_q, sig_m, gold;
    logic [3:0] ma, mb;
    logic       inj_en = 1'b0, stuck = 1'b0, zero = 1'b0;
    logic [7:0] inj_v = 8'h00, inj_p = 8'h00;

    assign mul_busy = busy_q;
    assign mul_product = prod_q;

    function automatic logic [7:0] res(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb, p;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        p = sa * sb;
        if (zero) return 8'h00;
        if (inj_en && {a, b} == inj_v) return inj_p;
        return p;
    endfunction

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] p);
        return {s[6:0], ^(s & 8'hB8)} ^ p;
    endfunction

    always @(posedge clk) if (mul_start) starts <= starts + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt    <= 0;
            prod_q <= 8'h00;
            sig_m  <= 8'h00;
        end else if (mul_start) begin
            busy_q <= 1'b1;
            cnt    <= 4;
            ma     <= mul_a;
            mb     <= mul_b;
            if ({mul_a, mul_b} == 8'h00) sig_m <= 8'h00;
        end else if (cnt > 1) cnt <= cnt - 1;
        else if (cnt == 1 && !(stuck && {ma, mb} == 8'h03)) begin
            cnt    <= 0;
            busy_q <= 1'b0;
            prod_q <= res(ma, mb);
            if (bist_en) sig_m <= misr(sig_m, res(ma, mb));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input logic [7:0] v);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(mul_start && {mul_a, mul_b} == v) && n < 4000);
        if (!(mul_start && {mul_a, mul_b} == v)) begin
            checks++;
            errors++;
            $display("FAIL wait_start %02h: no pulse within %0d cycles", v, n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 4000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done never rose in %0d cycles", n);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        bist_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s0 = starts;
        bist_en = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{4'h4, 4'h7, 8'h1C, 8'd0, 1'b1};
        tbl[1] = '{4'h4, 4'h7, 8'h1D, 8'd1, 1'b0};
        tbl[2] = '{4'hC, 4'h5, 8'hEC, 8'd0, 1'b1};
        tbl[3] = '{4'h8, 4'h8, 8'h40, 8'd0, 1'b1};
        tbl[4] = '{4'hC, 4'h5, 8'h3C, 8'd1, 1'b0};
        tbl[5] = '{4'h7, 4'h8, 8'hC8, 8'd0, 1'b1};
        gold = 8'h00;

        // asynchronous reset in the middle of a vector
        start_run();
        wait_start(8'h12);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        bist_en = 1'b0;
        #1 check("reset_async", {mul_a, mul_b, mul_start, done, pass, timeout, err_count, signature}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        repeat (5) @(negedge clk);
        check("idle_no_start", starts - s0, 0);
        check("idle_done", done, 0);

        // full sweeps with one table-selected product per run
        for (int i = 0; i < 6; i++) begin
            inj_en = 1'b1;
            inj_v = {tbl[i].a, tbl[i].b};
            inj_p = tbl[i].prod;
            start_run();
            wait_done();
            check($sformatf("t%0d_starts", i), starts - s0, 256);
            check($sformatf("t%0d_done", i), done, 1);
            check($sformatf("t%0d_pass", i), pass, tbl[i].exp_pass);
            check($sformatf("t%0d_err", i), err_count, tbl[i].exp_err);
            check($sformatf("t%0d_sig", i), signature, sig_m);
            if (i == 0) gold = sig_m;
            if (i == 1) check("fault_sig_differs", 32'(signature != gold), 1);
        end
        inj_en = 1'b0;

        // multiplier stuck busy on vector 3
        stuck = 1'b1;
        start_run();
        wait_start(8'h03);
        repeat (16) @(negedge clk);
        check("stuck_before_to", timeout, 0);
        @(negedge clk);
        check("stuck_timeout", timeout, 1);
        check("stuck_done", done, 1);
        repeat (5) @(negedge clk);
        check("stuck_starts", starts - s0, 4);
        check("stuck_pass", pass, 0);
        check("stuck_err", err_count, 0);
        check("stuck_hold_done", done, 1);
        stuck = 1'b0;

        // abort during vector 10 then restart without reset
        start_run();
        wait_start(8'h0A);
        @(negedge clk);
        bist_en = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_start", mul_start, 0);
        repeat (8) @(negedge clk);
        s0 = starts;
        bist_en = 1'b1;
        @(negedge clk);
        check("restart_pulse", mul_start, 1);
        check("restart_ops", {mul_a, mul_b}, 8'h00);
        check("restart_err", err_count, 0);
        wait_done();
        check("restart_starts", starts - s0, 256);
        check("restart_pass", pass, 1);
        check("restart_sig", signature, gold);

        // zero-returning multiplier: natural count then forced saturation
        zero = 1'b1;
        start_run();
        wait_start(8'h20);
        check("zero_err_mid", err_count, 15);
        wait_done();
        check("zero_err_end", err_count, 225);
        check("zero_pass", pass, 0);
        check("zero_sig", signature, sig_m);
        start_run();
        wait_start(8'h11);
        force dut.err_count = 8'd254;
        @(negedge clk);
        release dut.err_count;
        wait_start(8'h12);
        check("sat_reach", err_count, 255);
        wait_start(8'h13);
        check("sat_hold", err_count, 255);
        wait_done();
        check("sat_end", err_count, 255);
        check("sat_pass", pass, 0);
        zero = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
